// File: rtl/sextium_seq_controller.sv
// Sextium sequencer: fetches packed opcode words, steps through slots.
// Ports: clock/reset, insn+flags in, registered strobes/selects out.
module sextium_seq_controller #(
  parameter int SLOTS = 4,
  parameter int OPW = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [OPW-1:0]             insn,
  input  logic                       accz,
  input  logic                       accn,
  input  logic                       iobusy,
  input  logic                       mem_ack,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic                       acc_write,
  output logic                       doswap,
  output logic                       runio,
  output logic                       seladdr,
  output logic                       selswap,
  output logic                       selpc1,
  output logic                       selpc2,
  output logic [1:0]                 selacc,
  output logic [1:0]                 aluinsn,
  output logic [$clog2(SLOTS)-1:0]   curinsn,
  output logic                       halted
);

  localparam int CW = $clog2(SLOTS);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_SYS   = OPW'(1);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(2);
  localparam logic [OPW-1:0] OP_STORE = OPW'(3);
  localparam logic [OPW-1:0] OP_SWAPA = OPW'(4);
  localparam logic [OPW-1:0] OP_SWAPD = OPW'(5);
  localparam logic [OPW-1:0] OP_BZ    = OPW'(6);
  localparam logic [OPW-1:0] OP_BN    = OPW'(7);
  localparam logic [OPW-1:0] OP_JUMP  = OPW'(8);
  localparam logic [OPW-1:0] OP_CONST = OPW'(9);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(10);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(13);

  typedef enum logic [2:0] {
    FETCH, FWAIT, DECODE, MEMWAIT, IOWAIT, NEXT, HALT
  } state_t;

  typedef struct packed {
    logic          mem_read;
    logic          mem_write;
    logic          ir_write;
    logic          pc_write;
    logic          acc_write;
    logic          doswap;
    logic          runio;
    logic          seladdr;
    logic          selswap;
    logic          selpc1;
    logic          selpc2;
    logic [1:0]    selacc;
    logic [1:0]    aluinsn;
    logic [CW-1:0] curinsn;
    logic          halted;
    logic          acc_ld;
    logic          cn;
    logic          last;
  } ctl_t;

  state_t state_q, state_d;
  ctl_t   o_q, o_d;

  logic illegal, is_mem, is_alu, take, end_w;

  assign illegal = insn > OP_DIV;
  assign is_mem  = (insn == OP_LOAD) || (insn == OP_STORE) ||
                   (insn == OP_CONST);
  assign is_alu  = (insn >= OP_ADD) && (insn <= OP_DIV);
  assign take    = (insn == OP_JUMP) || ((insn == OP_BZ) && accz) ||
                   ((insn == OP_BN) && accn);
  // A taken branch/jump ends the word early.
  assign end_w   = (o_q.curinsn == CW'(SLOTS - 1)) || o_q.last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (o_q.mem_read && mem_ack) state_d = FWAIT;
      FWAIT:   state_d = DECODE;
      DECODE: begin
        if (illegal)              state_d = HALT;
        else if (insn == OP_SYS)  state_d = IOWAIT;
        else if (is_mem)          state_d = MEMWAIT;
        else                      state_d = NEXT;
      end
      MEMWAIT: if (mem_ack) state_d = NEXT;
      IOWAIT:  if (!iobusy) state_d = NEXT;
      NEXT:    state_d = end_w ? FETCH : DECODE;
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    o_d = o_q;
    unique case (state_q)
      FETCH: begin
        o_d.seladdr = 1'b0;
        // Ack only counts once the read request is actually out.
        if (o_q.mem_read && mem_ack) begin
          o_d.mem_read = 1'b0;
          o_d.ir_write = 1'b1;
          o_d.pc_write = 1'b1;
          o_d.selpc1   = 1'b0;
          o_d.curinsn  = '0;
          o_d.last     = 1'b0;
        end else begin
          o_d.mem_read = 1'b1;
        end
      end
      FWAIT: begin
        o_d.ir_write = 1'b0;
        o_d.pc_write = 1'b0;
      end
      DECODE: begin
        unique case (1'b1)
          insn == OP_NOP: ;
          insn == OP_SYS: begin
            o_d.runio  = 1'b1;
            o_d.selacc = 2'd1;
          end
          insn == OP_LOAD: begin
            o_d.mem_read = 1'b1;
            o_d.seladdr  = 1'b1;
            o_d.selacc   = 2'd0;
            o_d.acc_ld   = 1'b1;
            o_d.cn       = 1'b0;
          end
          insn == OP_STORE: begin
            o_d.mem_write = 1'b1;
            o_d.seladdr   = 1'b1;
            o_d.acc_ld    = 1'b0;
            o_d.cn        = 1'b0;
          end
          insn == OP_CONST: begin
            o_d.mem_read = 1'b1;
            o_d.seladdr  = 1'b0;
            o_d.selacc   = 2'd0;
            o_d.acc_ld   = 1'b1;
            o_d.cn       = 1'b1;
          end
          insn == OP_SWAPA, insn == OP_SWAPD: begin
            o_d.acc_write = 1'b1;
            o_d.doswap    = 1'b1;
            o_d.selacc    = 2'd2;
            o_d.selswap   = insn == OP_SWAPD;
          end
          insn == OP_BZ, insn == OP_BN, insn == OP_JUMP: begin
            if (take) begin
              o_d.pc_write = 1'b1;
              o_d.selpc1   = 1'b1;
              o_d.selpc2   = insn == OP_JUMP;
              o_d.last     = 1'b1;
            end
          end
          is_alu: begin
            o_d.acc_write = 1'b1;
            o_d.selacc    = 2'd3;
            o_d.aluinsn   = 2'(insn - OP_ADD);
          end
          default: o_d.halted = 1'b1;
        endcase
      end
      MEMWAIT: begin
        if (mem_ack) begin
          o_d.mem_read  = 1'b0;
          o_d.mem_write = 1'b0;
          o_d.seladdr   = 1'b0;
          o_d.acc_write = o_q.acc_ld;
          // CONST consumed the word after the instruction; step PC past it.
          if (o_q.cn) begin
            o_d.pc_write = 1'b1;
            o_d.selpc1   = 1'b0;
          end
        end
      end
      IOWAIT: begin
        if (!iobusy) begin
          o_d.runio     = 1'b0;
          o_d.acc_write = 1'b1;
        end
      end
      NEXT: begin
        o_d.mem_read  = 1'b0;
        o_d.mem_write = 1'b0;
        o_d.ir_write  = 1'b0;
        o_d.pc_write  = 1'b0;
        o_d.acc_write = 1'b0;
        o_d.doswap    = 1'b0;
        o_d.runio     = 1'b0;
        if (end_w) o_d.last = 1'b0;
        else       o_d.curinsn = o_q.curinsn + CW'(1);
      end
      default: ;
    endcase
  end

  assign mem_read  = o_q.mem_read;
  assign mem_write = o_q.mem_write;
  assign ir_write  = o_q.ir_write;
  assign pc_write  = o_q.pc_write;
  assign acc_write = o_q.acc_write;
  assign doswap    = o_q.doswap;
  assign runio     = o_q.runio;
  assign seladdr   = o_q.seladdr;
  assign selswap   = o_q.selswap;
  assign selpc1    = o_q.selpc1;
  assign selpc2    = o_q.selpc2;
  assign selacc    = o_q.selacc;
  assign aluinsn   = o_q.aluinsn;
  assign curinsn   = o_q.curinsn;
  assign halted    = o_q.halted;

endmodule

// File: tb/tb_sextium_seq_controller.sv
// Directed bench for sextium_seq_controller (default and 8x6 builds).
// Ports: drives both instances, checks registered outputs after edges.
module tb_sextium_seq_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic [15:0] word_p = '0;
  logic [3:0]  insn;
  logic        accz = 0, accn = 0, iobusy = 0, mem_ack = 0;
  logic        mem_read, mem_write, ir_write, pc_write, acc_write;
  logic        doswap, runio, seladdr, selswap, selpc1, selpc2, halted;
  logic [1:0]  selacc, aluinsn, curinsn;

  logic [5:0]  insn8 = 6'd10;
  logic        mem_ack8 = 0;
  logic        mem_read8, mem_write8, ir_write8, pc_write8, acc_write8;
  logic        doswap8, runio8, seladdr8, selswap8, selpc18, selpc28;
  logic        halted8;
  logic [1:0]  selacc8, aluinsn8;
  logic [2:0]  curinsn8;

  logic [6:0]  stb, stb8;
  int tests = 0;
  int fails = 0;

  assign insn = word_p[curinsn*4 +: 4];
  assign stb  = {mem_read, mem_write, ir_write, pc_write,
                 acc_write, doswap, runio};
  assign stb8 = {mem_read8, mem_write8, ir_write8, pc_write8,
                 acc_write8, doswap8, runio8};

  sextium_seq_controller dut (
    .clock(clock), .reset(reset), .insn(insn),
    .accz(accz), .accn(accn), .iobusy(iobusy), .mem_ack(mem_ack),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .acc_write(acc_write), .doswap(doswap),
    .runio(runio), .seladdr(seladdr), .selswap(selswap),
    .selpc1(selpc1), .selpc2(selpc2), .selacc(selacc),
    .aluinsn(aluinsn), .curinsn(curinsn), .halted(halted)
  );

  sextium_seq_controller #(.SLOTS(8), .OPW(6)) dut8 (
    .clock(clock), .reset(reset), .insn(insn8),
    .accz(accz), .accn(accn), .iobusy(iobusy), .mem_ack(mem_ack8),
    .mem_read(mem_read8), .mem_write(mem_write8),
    .ir_write(ir_write8), .pc_write(pc_write8),
    .acc_write(acc_write8), .doswap(doswap8), .runio(runio8),
    .seladdr(seladdr8), .selswap(selswap8), .selpc1(selpc18),
    .selpc2(selpc28), .selacc(selacc8), .aluinsn(aluinsn8),
    .curinsn(curinsn8), .halted(halted8)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clock);
    #1;
    reset = 0;
    mem_ack = 0; mem_ack8 = 0; iobusy = 0; accz = 0; accn = 0;
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  // Reset, then fetch word w; the next edge decodes slot 0.
  task automatic start_word(input logic [15:0] w);
    word_p = w;
    reset_dut();
    step();
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
  endtask

  task automatic test_reset();
    #2 reset = 0;
    #1;
    tests++;
    if ({stb, seladdr, selswap, selpc1, selpc2, selacc, aluinsn,
         curinsn, halted} !== '0) begin
      fails++;
      $display("FAIL reset_outs got %b/%b%b%b%b/%h/%h/%h/%b want 0",
               stb, seladdr, selswap, selpc1, selpc2, selacc,
               aluinsn, curinsn, halted);
    end
    tests++;
    if ({stb8, seladdr8, selswap8, selpc18, selpc28, selacc8,
         aluinsn8, curinsn8, halted8} !== '0) begin
      fails++;
      $display("FAIL reset_outs8 got %b cur %0d want 0", stb8, curinsn8);
    end
  endtask

  task automatic test_fetch_nop();
    int rd;
    logic [1:0] exp_c [8];
    exp_c = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    word_p = 16'h0000;
    reset_dut();
    rd = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_read === 1'b1) rd++;
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    tests++;
    if ({ir_write, pc_write, mem_read, selpc1, curinsn} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL fetch_ack got %b%b%b%b cur %0d want 1100 cur 0",
               ir_write, pc_write, mem_read, selpc1, curinsn);
    end
    tests++;
    if (rd != 4) begin
      fails++;
      $display("FAIL fetch_rd_cycles got %0d want 4", rd);
    end
    step();
    tests++;
    if (stb !== 7'b0) begin
      fails++;
      $display("FAIL fwait_stb got %b want 0", stb);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if ({stb, curinsn} !== {7'b0, exp_c[i]}) begin
        fails++;
        $display("FAIL nop_seq[%0d] got stb %b cur %0d want 0 cur %0d",
                 i, stb, curinsn, exp_c[i]);
      end
    end
    step();
    tests++;
    if ({mem_read, seladdr} !== 2'b10) begin
      fails++;
      $display("FAIL refetch got rd %b sa %b want 1 0", mem_read, seladdr);
    end
  endtask

  task automatic test_load();
    int sa;
    start_word(16'h0020);
    step();
    step();
    sa = 0;
    step();
    tests++;
    if ({mem_read, mem_write, seladdr, selacc, curinsn} !==
        {1'b1, 1'b0, 1'b1, 2'd0, 2'd1}) begin
      fails++;
      $display("FAIL load_issue got %b%b%b sel %0d cur %0d want 101 0 1",
               mem_read, mem_write, seladdr, selacc, curinsn);
    end
    if (seladdr === 1'b1) sa++;
    for (int i = 0; i < 2; i++) begin
      step();
      if (seladdr === 1'b1) sa++;
      tests++;
      if ({mem_read, acc_write} !== 2'b10) begin
        fails++;
        $display("FAIL load_wait[%0d] got rd %b aw %b want 1 0",
                 i, mem_read, acc_write);
      end
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    if (seladdr === 1'b1) sa++;
    tests++;
    if ({mem_read, seladdr, acc_write, pc_write, selacc} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL load_ack got %b%b%b%b sel %0d want 0010 0",
               mem_read, seladdr, acc_write, pc_write, selacc);
    end
    tests++;
    if (sa != 3) begin
      fails++;
      $display("FAIL load_seladdr_cycles got %0d want 3", sa);
    end
    step();
    tests++;
    if ({acc_write, curinsn} !== {1'b0, 2'd2}) begin
      fails++;
      $display("FAIL load_next got aw %b cur %0d want 0 2",
               acc_write, curinsn);
    end
  endtask

  task automatic test_const_store();
    start_word(16'h0009);
    step();
    tests++;
    if ({mem_read, seladdr, selacc, pc_write} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL const_issue got %b%b %0d %b want 10 0 0",
               mem_read, seladdr, selacc, pc_write);
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    tests++;
    if ({mem_read, acc_write, pc_write, selpc1} !== 4'b0110) begin
      fails++;
      $display("FAIL const_ack got %b%b%b%b want 0110",
               mem_read, acc_write, pc_write, selpc1);
    end
    step();
    tests++;
    if ({stb, curinsn} !== {7'b0, 2'd1}) begin
      fails++;
      $display("FAIL const_next got %b cur %0d want 0 1", stb, curinsn);
    end
    start_word(16'h0003);
    step();
    step();
    tests++;
    if ({mem_read, mem_write, seladdr} !== 3'b011) begin
      fails++;
      $display("FAIL store_hold got %b%b%b want 011",
               mem_read, mem_write, seladdr);
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    tests++;
    if ({mem_write, seladdr, acc_write, pc_write} !== 4'b0000) begin
      fails++;
      $display("FAIL store_ack got %b%b%b%b want 0000",
               mem_write, seladdr, acc_write, pc_write);
    end
  endtask

  task automatic test_branch();
    start_word(16'h0006);
    accz = 1;
    step();
    tests++;
    if ({pc_write, selpc1, selpc2, acc_write} !== 4'b1100) begin
      fails++;
      $display("FAIL bz_taken got %b%b%b%b want 1100",
               pc_write, selpc1, selpc2, acc_write);
    end
    step();
    step();
    tests++;
    if ({mem_read, pc_write, curinsn} !== {1'b1, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL bz_refetch got rd %b pw %b cur %0d want 1 0 0",
               mem_read, pc_write, curinsn);
    end
    start_word(16'h0006);
    step();
    tests++;
    if (stb !== 7'b0) begin
      fails++;
      $display("FAIL bz_untaken got %b want 0", stb);
    end
    step();
    tests++;
    if ({stb, curinsn} !== {7'b0, 2'd1}) begin
      fails++;
      $display("FAIL bz_untaken_next got %b cur %0d want 0 1", stb, curinsn);
    end
    start_word(16'h0070);
    accn = 1;
    step();
    step();
    step();
    tests++;
    if ({pc_write, selpc1, selpc2, curinsn} !== {3'b110, 2'd1}) begin
      fails++;
      $display("FAIL bn_taken got %b%b%b cur %0d want 110 1",
               pc_write, selpc1, selpc2, curinsn);
    end
    step();
    step();
    tests++;
    if ({mem_read, curinsn} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL bn_word_end got rd %b cur %0d want 1 1",
               mem_read, curinsn);
    end
    start_word(16'h0008);
    step();
    tests++;
    if ({pc_write, selpc1, selpc2} !== 3'b111) begin
      fails++;
      $display("FAIL jump got %b%b%b want 111", pc_write, selpc1, selpc2);
    end
  endtask

  task automatic test_syscall();
    int runs;
    start_word(16'h0001);
    runs = 0;
    step();
    if (runio === 1'b1) runs++;
    tests++;
    if ({runio, selacc} !== {1'b1, 2'd1}) begin
      fails++;
      $display("FAIL sys_issue got run %b sel %0d want 1 1", runio, selacc);
    end
    iobusy = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (runio === 1'b1) runs++;
      tests++;
      if (acc_write !== 1'b0) begin
        fails++;
        $display("FAIL sys_wait[%0d] got aw %b want 0", i, acc_write);
      end
    end
    iobusy = 0;
    step();
    tests++;
    if ({runio, acc_write, selacc} !== {1'b0, 1'b1, 2'd1}) begin
      fails++;
      $display("FAIL sys_done got %b%b sel %0d want 01 1",
               runio, acc_write, selacc);
    end
    tests++;
    if (runs != 6) begin
      fails++;
      $display("FAIL sys_runio_cycles got %0d want 6", runs);
    end
    step();
    tests++;
    if ({stb, curinsn} !== {7'b0, 2'd1}) begin
      fails++;
      $display("FAIL sys_next got %b cur %0d want 0 1", stb, curinsn);
    end
  endtask

  task automatic test_onecycle();
    logic [3:0] ops [6];
    logic [5:0] exp_o [6];
    ops   = '{4'd4, 4'd5, 4'd10, 4'd11, 4'd12, 4'd13};
    exp_o = '{6'b1_10_0_00, 6'b1_10_1_00, 6'b0_11_0_00,
              6'b0_11_0_01, 6'b0_11_0_10, 6'b0_11_0_11};
    for (int i = 0; i < 6; i++) begin
      start_word({12'h000, ops[i]});
      step();
      tests++;
      if ({acc_write, pc_write, doswap, selacc, selswap, aluinsn} !==
          {2'b10, exp_o[i]}) begin
        fails++;
        $display("FAIL op%0d_exec got %b%b %b want 10 %b", ops[i],
                 acc_write, pc_write,
                 {doswap, selacc, selswap, aluinsn}, exp_o[i]);
      end
      step();
      tests++;
      if ({stb, curinsn} !== {7'b0, 2'd1}) begin
        fails++;
        $display("FAIL op%0d_next got %b cur %0d want 0 1",
                 ops[i], stb, curinsn);
      end
    end
  endtask

  task automatic test_halt();
    start_word(16'h0F00);
    for (int i = 0; i < 4; i++) step();
    step();
    tests++;
    if ({stb, halted, curinsn} !== {7'b0, 1'b1, 2'd2}) begin
      fails++;
      $display("FAIL halt_enter got %b h %b cur %0d want 0 1 2",
               stb, halted, curinsn);
    end
    mem_ack = 1;
    iobusy = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if ({stb, halted} !== {7'b0, 1'b1}) begin
        fails++;
        $display("FAIL halt_hold[%0d] got %b h %b want 0 1",
                 i, stb, halted);
      end
    end
    mem_ack = 0;
    iobusy = 0;
    reset = 0;
    #1;
    tests++;
    if ({halted, curinsn} !== {1'b0, 2'd0}) begin
      fails++;
      $display("FAIL halt_reset got h %b cur %0d want 0 0",
               halted, curinsn);
    end
    step();
    reset = 1;
    step();
    tests++;
    if ({mem_read, halted} !== 2'b10) begin
      fails++;
      $display("FAIL halt_restart got rd %b h %b want 1 0",
               mem_read, halted);
    end
  endtask

  task automatic test_reset_midwait();
    start_word(16'h0002);
    step();
    #1 reset = 0;
    #1;
    tests++;
    if ({mem_read, seladdr} !== 2'b00) begin
      fails++;
      $display("FAIL rst_memwait got rd %b sa %b want 0 0",
               mem_read, seladdr);
    end
    start_word(16'h0001);
    iobusy = 1;
    step();
    step();
    #1 reset = 0;
    #1;
    tests++;
    if (runio !== 1'b0) begin
      fails++;
      $display("FAIL rst_iowait got runio %b want 0", runio);
    end
    iobusy = 0;
    reset_dut();
  endtask

  task automatic test_wide();
    reset_dut();
    step();
    tests++;
    if (mem_read8 !== 1'b1) begin
      fails++;
      $display("FAIL w_fetch got rd %b want 1", mem_read8);
    end
    mem_ack8 = 1;
    step();
    mem_ack8 = 0;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      tests++;
      if ({acc_write8, aluinsn8, selacc8, curinsn8} !==
          {1'b1, 2'd0, 2'd3, 3'(k)}) begin
        fails++;
        $display("FAIL w_add[%0d] got aw %b alu %0d sel %0d cur %0d want 1 0 3 %0d",
                 k, acc_write8, aluinsn8, selacc8, curinsn8, k);
      end
      step();
      tests++;
      if (stb8 !== 7'b0) begin
        fails++;
        $display("FAIL w_next[%0d] got %b want 0", k, stb8);
      end
    end
    step();
    tests++;
    if ({mem_read8, curinsn8} !== {1'b1, 3'd7}) begin
      fails++;
      $display("FAIL w_refetch got rd %b cur %0d want 1 7",
               mem_read8, curinsn8);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_nop();
    test_load();
    test_const_store();
    test_branch();
    test_syscall();
    test_onecycle();
    test_halt();
    test_reset_midwait();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
